// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM sequencer for IF and MEM clients; optional IO write stall via MEM_CTRL_IO_STALL_EN
module mem_ctrl #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h00030000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_enable,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              mem_enable,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_len,
   input  logic [31:0]       mem_wdata,
   input  logic              io_buffer_full,
   input  logic [7:0]        ram_din,
   output logic [ADDR_W-1:0] ram_a,
   output logic [7:0]        ram_dout,
   output logic              ram_wr,
   output logic              if_finished,
   output logic [31:0]       inst_o,
   output logic              if_busy,
   output logic              mem_busy,
   output logic              mem_finished,
   output logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, MEM_RD = 2'd2, MEM_WR = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_wr_q, ram_wr_d;
   logic              if_fin_q, if_fin_d;
   logic [31:0]       inst_q, inst_d;
   logic              mem_fin_q, mem_fin_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [2:0]        mem_len_n;
   logic [ADDR_W-1:0] wr_base, wr_addr;
   logic [1:0]        wr_k;
   logic [31:0]       wr_data;
   logic [7:0]        wr_byte;
   logic              io_stall;
   logic [1:0]        rd_idx;
   logic [31:0]       rd_word;

   assign mem_len_n = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
   assign rd_idx    = cnt_q[1:0] - 2'd1;

   // byte to issue next on a store: byte 0 comes straight from the request while idle
   always_comb begin
      if (state_q == IDLE) begin
         wr_base = mem_addr;
         wr_k    = 2'd0;
         wr_data = mem_wdata;
      end else begin
         wr_base = base_q;
         wr_k    = cnt_q[1:0];
         wr_data = wdata_q;
      end
      wr_addr = wr_base + ADDR_W'(wr_k);
      wr_byte = 8'(wr_data >> {wr_k, 3'b000});
   end

`ifdef MEM_CTRL_IO_STALL_EN
   assign io_stall = io_buffer_full && (wr_base >= IO_BASE);
`else
   logic unused_io;
   assign unused_io = io_buffer_full | (wr_base >= IO_BASE);
   assign io_stall  = 1'b0;
`endif

   // merge the byte arriving on ram_din into the partially assembled word
   always_comb begin
      rd_word = buf_q;
      rd_word[{rd_idx, 3'b000} +: 8] = ram_din;
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // next state: MEM wins arbitration, transactions run to their last byte
   always_comb begin
      state_d = state_q;
      if (rdy) begin
         case (state_q)
            IDLE: begin
               if (mem_enable)     state_d = mem_wr ? MEM_WR : MEM_RD;
               else if (if_enable) state_d = IF_RD;
            end
            IF_RD, MEM_RD, MEM_WR: begin
               if (cnt_q == len_q) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // datapath and registered outputs; rdy low holds everything
   always_comb begin
      base_d     = base_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      ram_a_d    = ram_a_q;
      ram_dout_d = ram_dout_q;
      ram_wr_d   = ram_wr_q;
      if_fin_d   = if_fin_q;
      inst_d     = inst_q;
      mem_fin_d  = mem_fin_q;
      rdata_d    = rdata_q;
      if (rdy) begin
         if_fin_d  = 1'b0;
         mem_fin_d = 1'b0;
         case (state_q)
            IDLE: begin
               ram_wr_d = 1'b0;
               if (mem_enable) begin
                  base_d  = mem_addr;
                  len_d   = mem_len_n;
                  wdata_d = mem_wdata;
                  buf_d   = '0;
                  cnt_d   = 3'd1;
                  if (!mem_wr) begin
                     ram_a_d = mem_addr;
                  end else if (io_stall) begin
                     cnt_d = 3'd0;
                  end else begin
                     ram_a_d    = wr_addr;
                     ram_dout_d = wr_byte;
                     ram_wr_d   = 1'b1;
                  end
               end else if (if_enable) begin
                  base_d  = if_addr;
                  len_d   = 3'd4;
                  buf_d   = '0;
                  cnt_d   = 3'd1;
                  ram_a_d = if_addr;
               end
            end
            IF_RD, MEM_RD: begin
               buf_d = rd_word;
               if (cnt_q == len_q) begin
                  if (state_q == IF_RD) begin
                     if_fin_d = 1'b1;
                     inst_d   = rd_word;
                  end else begin
                     mem_fin_d = 1'b1;
                     rdata_d   = rd_word;
                  end
               end else begin
                  ram_a_d = base_q + ADDR_W'(cnt_q);
                  cnt_d   = cnt_q + 3'd1;
               end
            end
            MEM_WR: begin
               if (cnt_q == len_q) begin
                  ram_wr_d  = 1'b0;
                  mem_fin_d = 1'b1;
               end else if (io_stall) begin
                  ram_wr_d = 1'b0;
               end else begin
                  ram_a_d    = wr_addr;
                  ram_dout_d = wr_byte;
                  ram_wr_d   = 1'b1;
                  cnt_d      = cnt_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q     <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         wdata_q    <= '0;
         buf_q      <= '0;
         ram_a_q    <= '0;
         ram_dout_q <= '0;
         ram_wr_q   <= 1'b0;
         if_fin_q   <= 1'b0;
         inst_q     <= '0;
         mem_fin_q  <= 1'b0;
         rdata_q    <= '0;
      end else begin
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         ram_a_q    <= ram_a_d;
         ram_dout_q <= ram_dout_d;
         ram_wr_q   <= ram_wr_d;
         if_fin_q   <= if_fin_d;
         inst_q     <= inst_d;
         mem_fin_q  <= mem_fin_d;
         rdata_q    <= rdata_d;
      end
   end

   assign ram_a        = ram_a_q;
   assign ram_dout     = ram_dout_q;
   assign ram_wr       = ram_wr_q;
   assign if_finished  = if_fin_q;
   assign inst_o       = inst_q;
   assign mem_finished = mem_fin_q;
   assign mem_rdata    = rdata_q;
   assign if_busy      = (state_q == IF_RD);
   assign mem_busy     = (state_q == MEM_RD) || (state_q == MEM_WR) || ((state_q == IDLE) && mem_enable);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, if_enable, mem_enable, mem_wr, io_buffer_full;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [1:0]  mem_len;
   logic [7:0]  ram_din, ram_dout;
   logic [31:0] ram_a, inst_o, mem_rdata;
   logic        ram_wr, if_finished, if_busy, mem_busy, mem_finished;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] ram_mem [0:65535];
   logic [7:0] shadow  [0:65535];
   bit         pre_we = 1'b0;
   logic [15:0] pre_a;
   logic [7:0]  pre_d;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_enable(if_enable), .if_addr(if_addr),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_len(mem_len), .mem_wdata(mem_wdata),
      .io_buffer_full(io_buffer_full), .ram_din(ram_din),
      .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
      .if_finished(if_finished), .inst_o(inst_o), .if_busy(if_busy),
      .mem_busy(mem_busy), .mem_finished(mem_finished), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(int i);
      return 8'((i * 37) ^ (i >> 7) ^ 8'h5a);
   endfunction

   // RAM: combinational read of the registered address, writes gated by rdy
   assign ram_din = ram_mem[ram_a[15:0]];
   initial begin
      for (int i = 0; i < 65536; i++) ram_mem[i] = init_byte(i);
      forever begin
         @(posedge clk);
         if (pre_we) ram_mem[pre_a] <= pre_d;
         if (rdy && ram_wr) ram_mem[ram_a[15:0]] <= ram_dout;
      end
   end

   function automatic int nbytes(logic [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_load(logic [31:0] addr, logic [1:0] len);
      logic [31:0] v, a;
      v = '0;
      for (int i = 0; i < nbytes(len); i++) begin
         a = addr + 32'(i);
         v = v | (32'(shadow[a[15:0]]) << (8 * i));
      end
      return v;
   endfunction

   task automatic model_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] wdata);
      logic [31:0] a;
      for (int i = 0; i < nbytes(len); i++) begin
         a = addr + 32'(i);
         shadow[a[15:0]] = 8'(wdata >> (8 * i));
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      pre_a = a; pre_d = d; pre_we = 1'b1; shadow[a] = d;
      @(negedge clk);
      pre_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_if(input logic [31:0] addr, output logic [31:0] data, output int lat,
                         output int fin_cyc, output bit seq_ok, output bit pulse_ok);
      lat = -1; fin_cyc = 0; seq_ok = 1'b1; pulse_ok = 1'b0; data = '0;
      if_addr = addr; if_enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j <= 4 && (ram_a !== addr + 32'(j - 1) || if_busy !== 1'b1)) seq_ok = 1'b0;
         if (if_finished === 1'b1) begin
            lat = j; fin_cyc = cyc; data = inst_o;
            break;
         end
      end
      if_enable = 1'b0;
      @(negedge clk);
      pulse_ok = (if_finished === 1'b0) && (inst_o === data);
   endtask

   task automatic run_mem(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata, output logic [31:0] data, output int lat,
                          output int wrcnt, output bit seq_ok, output bit pulse_ok);
      int n;
      n = nbytes(len);
      lat = -1; wrcnt = 0; seq_ok = 1'b1; pulse_ok = 1'b0; data = '0;
      mem_wr = wr; mem_addr = addr; mem_len = len; mem_wdata = wdata; mem_enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (mem_busy !== 1'b1) seq_ok = 1'b0;
         if (!wr && j <= n && ram_a !== addr + 32'(j - 1)) seq_ok = 1'b0;
         if (ram_wr === 1'b1) begin
            if (!wr || wrcnt >= n || ram_a !== addr + 32'(wrcnt) || ram_dout !== 8'(wdata >> (8 * wrcnt)))
               seq_ok = 1'b0;
            wrcnt++;
         end
         if (mem_finished === 1'b1) begin
            lat = j; data = mem_rdata;
            break;
         end
      end
      mem_enable = 1'b0;
      @(negedge clk);
      pulse_ok = (mem_finished === 1'b0) && (wr || mem_rdata === data);
   endtask

   task automatic test_reset;
      logic [108:0] outs;
      logic [31:0]  wd;
      bit           seen;
      rst = 1'b0; rdy = 1'b1; if_enable = 1'b0; mem_enable = 1'b0; mem_wr = 1'b0;
      if_addr = '0; mem_addr = '0; mem_len = '0; mem_wdata = '0; io_buffer_full = 1'b0;
      repeat (3) @(negedge clk);
      outs = {ram_a, ram_dout, ram_wr, if_finished, inst_o, if_busy, mem_busy, mem_finished, mem_rdata};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      rst = 1'b1;
      @(negedge clk);
      if_addr = 32'h7E00; if_enable = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (if_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b expected 1", if_busy); end
      rst = 1'b0;
      #1;
      outs = {ram_a, ram_dout, ram_wr, if_finished, inst_o, if_busy, mem_busy, mem_finished, mem_rdata};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_mid_read: got %h expected 0", outs); end
      if_enable = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (if_finished !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL reset_no_pulse: got pulse expected none"); end
      wd = $urandom;
      mem_addr = 32'h7F00; mem_wr = 1'b1; mem_len = 2'd2; mem_wdata = wd; mem_enable = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ram_wr !== 1'b1) begin errors++; $display("FAIL reset_pre_wr: got %b expected 1", ram_wr); end
      rst = 1'b0;
      #1;
      checks++;
      if (ram_wr !== 1'b0 || ram_a !== 32'h0) begin
         errors++; $display("FAIL reset_mid_write: got wr=%b a=%h expected wr=0 a=0", ram_wr, ram_a);
      end
      shadow[16'h7F00] = wd[7:0];
      mem_enable = 1'b0; mem_wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_if_fetch;
      logic [31:0] d, a, e;
      int lat, fc;
      bit sok, pok;
      poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
      run_if(32'h1000, d, lat, fc, sok, pok);
      checks++;
      if (d !== 32'h00000513) begin errors++; $display("FAIL if_fetch_data: got %h expected 00000513", d); end
      checks++;
      if (lat != 5) begin errors++; $display("FAIL if_fetch_latency: got %0d expected 5", lat); end
      checks++;
      if (!sok) begin errors++; $display("FAIL if_fetch_addr_seq: got bad sequence expected 1000..1003"); end
      checks++;
      if (!pok) begin errors++; $display("FAIL if_fetch_pulse: got pulse longer than one cycle or data changed"); end
      for (int i = 0; i < 6; i++) begin
         a = 32'h8000 + $urandom_range(0, 32'h7FF0);
         e = exp_load(a, 2'd2);
         run_if(a, d, lat, fc, sok, pok);
         checks++;
         if (d !== e || lat != 5 || !sok || !pok) begin
            errors++;
            $display("FAIL if_rand_fetch: addr %h got %h lat %0d expected %h lat 5", a, d, lat, e);
         end
      end
   endtask

   task automatic test_loads;
      logic [31:0] d, a, e;
      logic [1:0]  len;
      int lat, wc;
      bit sok, pok;
      poke(16'h2001, 8'hFF);
      run_mem(1'b0, 32'h2001, 2'd0, '0, d, lat, wc, sok, pok);
      checks++;
      if (d !== 32'h000000FF || lat != 2 || !sok || !pok) begin
         errors++; $display("FAIL load_byte: got %h lat %0d expected 000000ff lat 2", d, lat);
      end
      poke(16'h2000, 8'h34); poke(16'h2001, 8'h12);
      run_mem(1'b0, 32'h2000, 2'd1, '0, d, lat, wc, sok, pok);
      checks++;
      if (d !== 32'h00001234 || lat != 3 || !sok || !pok) begin
         errors++; $display("FAIL load_half: got %h lat %0d expected 00001234 lat 3", d, lat);
      end
      e = exp_load(32'hFFFFFFFF, 2'd1);
      run_mem(1'b0, 32'hFFFFFFFF, 2'd1, '0, d, lat, wc, sok, pok);
      checks++;
      if (d !== e || lat != 3 || !sok) begin
         errors++; $display("FAIL load_wrap: got %h lat %0d expected %h lat 3", d, lat, e);
      end
      for (int i = 0; i < 8; i++) begin
         a = 32'h8000 + $urandom_range(0, 32'h7FF0);
         len = 2'($urandom_range(0, 3));
         e = exp_load(a, len);
         run_mem(1'b0, a, len, '0, d, lat, wc, sok, pok);
         checks++;
         if (d !== e || lat != nbytes(len) + 1 || !sok || !pok || wc != 0) begin
            errors++;
            $display("FAIL load_rand: addr %h len %0d got %h lat %0d expected %h lat %0d", a, len, d, lat, e, nbytes(len) + 1);
         end
      end
   endtask

   task automatic test_store;
      logic [31:0] d, a, w, e;
      logic [1:0]  len;
      int lat, wc;
      bit sok, pok;
      run_mem(1'b1, 32'h3000, 2'd2, 32'hDEADBEEF, d, lat, wc, sok, pok);
      model_store(32'h3000, 2'd2, 32'hDEADBEEF);
      checks++;
      if (wc != 4 || lat != 5 || !sok || !pok) begin
         errors++; $display("FAIL store_word: got wr_cycles %0d lat %0d seq %b expected 4 5 1", wc, lat, sok);
      end
      run_mem(1'b0, 32'h3000, 2'd2, '0, d, lat, wc, sok, pok);
      checks++;
      if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL store_readback: got %h expected deadbeef", d); end
      for (int i = 0; i < 6; i++) begin
         a = 32'h8000 + $urandom_range(0, 32'h7FF0);
         len = 2'($urandom_range(0, 3));
         w = $urandom;
         run_mem(1'b1, a, len, w, d, lat, wc, sok, pok);
         model_store(a, len, w);
         checks++;
         if (wc != nbytes(len) || lat != nbytes(len) + 1 || !sok || !pok) begin
            errors++;
            $display("FAIL store_rand: addr %h len %0d got wr_cycles %0d lat %0d expected %0d %0d", a, len, wc, lat, nbytes(len), nbytes(len) + 1);
         end
         e = exp_load(a, 2'd2);
         run_mem(1'b0, a, 2'd2, '0, d, lat, wc, sok, pok);
         checks++;
         if (d !== e) begin errors++; $display("FAIL store_rand_readback: addr %h got %h expected %h", a, d, e); end
      end
   endtask

   task automatic test_simultaneous;
      logic [31:0] ia, ma, ie, me, id, md;
      logic [1:0]  len;
      int il, ml, n;
      bit mdone, busy_ok;
      for (int r = 0; r < 2; r++) begin
         ia = 32'h8000 + $urandom_range(0, 32'h7FF0);
         ma = 32'h8000 + $urandom_range(0, 32'h7FF0);
         len = 2'($urandom_range(0, 3));
         n = nbytes(len);
         ie = exp_load(ia, 2'd2); me = exp_load(ma, len);
         il = -1; ml = -1; mdone = 1'b0; busy_ok = 1'b1; id = '0; md = '0;
         if_addr = ia; mem_addr = ma; mem_len = len; mem_wr = 1'b0;
         if_enable = 1'b1; mem_enable = 1'b1;
         #1;
         if (mem_busy !== 1'b1) busy_ok = 1'b0;
         for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (!mdone && (mem_busy !== 1'b1 || if_busy !== 1'b0 || if_finished !== 1'b0)) busy_ok = 1'b0;
            if (mem_finished === 1'b1) begin ml = j; md = mem_rdata; mem_enable = 1'b0; mdone = 1'b1; end
            if (if_finished === 1'b1) begin il = j; id = inst_o; break; end
         end
         if_enable = 1'b0; mem_enable = 1'b0;
         @(negedge clk);
         checks++;
         if (ml != n + 1 || md !== me) begin
            errors++; $display("FAIL simul_mem: got lat %0d data %h expected lat %0d data %h", ml, md, n + 1, me);
         end
         checks++;
         if (il != n + 6 || id !== ie) begin
            errors++; $display("FAIL simul_if: got lat %0d data %h expected lat %0d data %h", il, id, n + 6, ie);
         end
         checks++;
         if (!busy_ok) begin errors++; $display("FAIL simul_busy: got overlap or busy drop expected MEM exclusive"); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, d, e;
      int lat, fc, prev;
      bit sok, pok;
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         a = 32'h8000 + $urandom_range(0, 32'h7FF0);
         e = exp_load(a, 2'd2);
         run_if(a, d, lat, fc, sok, pok);
         checks++;
         if (d !== e || (prev >= 0 && fc - prev != 6)) begin
            errors++; $display("FAIL back_to_back: got %h interval %0d expected %h interval 6", d, fc - prev, e);
         end
         prev = fc;
      end
   endtask

   task automatic test_rdy_stall;
      logic [31:0] a, e, d, hold;
      int lat;
      bit frozen_ok;
      a = 32'h8000 + $urandom_range(0, 32'h7FF0);
      e = exp_load(a, 2'd2);
      lat = -1; frozen_ok = 1'b1; hold = '0; d = '0;
      if_addr = a; if_enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j >= 3 && j <= 5 && (ram_a !== hold || if_finished !== 1'b0)) frozen_ok = 1'b0;
         if (j == 2) begin hold = ram_a; rdy = 1'b0; end
         if (j == 5) rdy = 1'b1;
         if (if_finished === 1'b1) begin lat = j; d = inst_o; break; end
      end
      if_enable = 1'b0; rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (lat != 8 || d !== e) begin
         errors++; $display("FAIL rdy_stall: got lat %0d data %h expected lat 8 data %h", lat, d, e);
      end
      checks++;
      if (!frozen_ok) begin errors++; $display("FAIL rdy_freeze: got state change while rdy low expected none"); end
   endtask

   task automatic test_io_stall;
      logic [31:0] w, d, e;
      int lat, first_wr, wc, exp_first, exp_lat, l2;
      bit sok, pok;
      w = $urandom;
      lat = -1; first_wr = -1;
      io_buffer_full = 1'b1;
      mem_wr = 1'b1; mem_addr = 32'h00030000; mem_len = 2'd0; mem_wdata = w; mem_enable = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (ram_wr === 1'b1 && first_wr < 0) first_wr = j;
         if (j == 2) io_buffer_full = 1'b0;
         if (mem_finished === 1'b1) begin lat = j; break; end
      end
      mem_enable = 1'b0; mem_wr = 1'b0; io_buffer_full = 1'b0;
      @(negedge clk);
      model_store(32'h00030000, 2'd0, w);
`ifdef MEM_CTRL_IO_STALL_EN
      exp_first = 3; exp_lat = 4;
`else
      exp_first = 1; exp_lat = 2;
`endif
      checks++;
      if (first_wr != exp_first || lat != exp_lat) begin
         errors++; $display("FAIL io_stall: got first_wr %0d lat %0d expected %0d %0d", first_wr, lat, exp_first, exp_lat);
      end
      e = exp_load(32'h00030000, 2'd0);
      run_mem(1'b0, 32'h00030000, 2'd0, '0, d, l2, wc, sok, pok);
      checks++;
      if (d !== e) begin errors++; $display("FAIL io_readback: got %h expected %h", d, e); end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) shadow[i] = init_byte(i);
      test_reset();
      test_if_fetch();
      test_loads();
      test_store();
      test_simultaneous();
      test_back_to_back();
      test_rdy_stall();
      test_io_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
